// File: rtl/lfsr_gen_pkg.sv
// Shared constants and types for the parametrised Galois LFSR generator.
// Tap masks are right-shift Galois masks (x^WIDTH term implied).
package lfsr_gen_pkg;

  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
  localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } lfsr_gen_state_e;

endpackage

// File: rtl/lfsr_step.sv
// Combinational single Galois LFSR step: d = (q >> 1) ^ (q[0] ? TAPS : 0).
module lfsr_step #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h8020_0003)
) (
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] d
);

  assign d = (q >> 1) ^ (q[0] ? TAPS : '0);

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Galois LFSR with seed load, valid/ready output and zero-seed guard.
// Optional period detection (wrap/period) is built when LFSR_GEN_PERIOD_CHK_EN is defined.
module lfsr_gen
  import lfsr_gen_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_32),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int unsigned      STEPS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             zero_seed,
  output logic             wrap,
  output logic [WIDTH-1:0] period
);

  lfsr_gen_state_e  fsm;
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] load_eff;
  logic             load_zero;
  logic             advance;
  logic             zero_seed_q;

  // chain[0] is the current state; chain[STEPS] is the state after one advance.
  logic [WIDTH-1:0] chain [STEPS+1];

  assign chain[0] = state_q;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_step (
      .q (chain[g]),
      .d (chain[g+1])
    );
  end

  assign load_zero = (load_val == '0);
  assign load_eff  = load_zero ? SEED : load_val;
  // A load wins over a simultaneous handshake, so the advance is suppressed.
  assign advance   = (fsm == RUN) && out_ready && !load;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm         <= IDLE;
      state_q     <= SEED;
      zero_seed_q <= 1'b0;
    end else begin
      zero_seed_q <= load && load_zero;
      if (load) begin
        fsm     <= RUN;
        state_q <= load_eff;
      end else if (advance) begin
        state_q <= chain[STEPS];
      end
    end
  end

  assign out_valid = (fsm == RUN);
  assign out_data  = state_q;
  assign zero_seed = zero_seed_q;

`ifdef LFSR_GEN_PERIOD_CHK_EN
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] adv_cnt;
  logic [WIDTH-1:0] cnt_inc;
  logic             wrap_q;
  logic [WIDTH-1:0] period_q;

  // Saturating increment: an all-ones counter stays all-ones.
  assign cnt_inc = (&adv_cnt) ? adv_cnt : adv_cnt + WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seed_q   <= SEED;
      adv_cnt  <= '0;
      wrap_q   <= 1'b0;
      period_q <= '0;
    end else begin
      wrap_q <= 1'b0;
      if (load) begin
        seed_q  <= load_eff;
        adv_cnt <= '0;
      end else if (advance) begin
        if (chain[STEPS] == seed_q) begin
          wrap_q   <= 1'b1;
          period_q <= cnt_inc;
          adv_cnt  <= '0;
        end else begin
          adv_cnt <= cnt_inc;
        end
      end
    end
  end

  assign wrap   = wrap_q;
  assign period = period_q;
`else
  assign wrap   = 1'b0;
  assign period = '0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed self-checking bench for lfsr_gen: default 32-bit build, a STEPS=2
// build and a 4-bit build (period outputs checked when LFSR_GEN_PERIOD_CHK_EN is set).
module tb_lfsr_gen;

  logic        clk = 1'b0;
  logic        reset;

  logic        load_a, ready_a, valid_a, zs_a, wrap_a;
  logic [31:0] lval_a, data_a, period_a;

  logic        load_b, ready_b, valid_b, zs_b, wrap_b;
  logic [31:0] lval_b, data_b, period_b;

  logic        load_c, ready_c, valid_c, zs_c, wrap_c;
  logic [3:0]  lval_c, data_c, period_c;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lfsr_gen u_dut_a (
    .clk (clk), .reset (reset), .load (load_a), .load_val (lval_a),
    .out_valid (valid_a), .out_ready (ready_a), .out_data (data_a),
    .zero_seed (zs_a), .wrap (wrap_a), .period (period_a)
  );

  lfsr_gen #(.STEPS(2)) u_dut_b (
    .clk (clk), .reset (reset), .load (load_b), .load_val (lval_b),
    .out_valid (valid_b), .out_ready (ready_b), .out_data (data_b),
    .zero_seed (zs_b), .wrap (wrap_b), .period (period_b)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'h9), .SEED(4'h1)) u_dut_c (
    .clk (clk), .reset (reset), .load (load_c), .load_val (lval_c),
    .out_valid (valid_c), .out_ready (ready_c), .out_data (data_c),
    .zero_seed (zs_c), .wrap (wrap_c), .period (period_c)
  );

  task automatic test_reset();
    reset = 1'b1;
    load_a = 0; ready_a = 0; lval_a = '0;
    load_b = 0; ready_b = 0; lval_b = '0;
    load_c = 0; ready_c = 0; lval_c = '0;
    #1;
    vectors++;
    if (valid_a !== 1'b0 || data_a !== 32'h1 || zs_a !== 1'b0 || wrap_a !== 1'b0 || period_a !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_a: valid=%b data=%h zs=%b wrap=%b period=%h, want 0 00000001 0 0 00000000",
               valid_a, data_a, zs_a, wrap_a, period_a);
    end
    vectors++;
    if (valid_c !== 1'b0 || data_c !== 4'h1 || wrap_c !== 1'b0 || period_c !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_c: valid=%b data=%h wrap=%b period=%h, want 0 1 0 0",
               valid_c, data_c, wrap_c, period_c);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (valid_a !== 1'b0 || data_a !== 32'h1) begin
      miscompares++;
      $display("FAIL idle_hold: valid=%b data=%h, want 0 00000001", valid_a, data_a);
    end
  endtask

  task automatic test_sequence();
    logic [31:0] exp_seq [4];
    exp_seq = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};
    load_a = 1; lval_a = 32'h1;
    @(negedge clk);
    load_a = 0;
    vectors++;
    if (valid_a !== 1'b1 || data_a !== exp_seq[0]) begin
      miscompares++;
      $display("FAIL seq_load: valid=%b data=%h, want 1 %h", valid_a, data_a, exp_seq[0]);
    end
    ready_a = 1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (data_a !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL seq_step%0d: data=%h, want %h", i, data_a, exp_seq[i]);
      end
    end
    ready_a = 0;
  endtask

  task automatic test_steps2();
    load_b = 1; lval_b = 32'h1;
    @(negedge clk);
    load_b = 0; ready_b = 1;
    @(negedge clk);
    ready_b = 0;
    vectors++;
    if (valid_b !== 1'b1 || data_b !== 32'hC030_0002) begin
      miscompares++;
      $display("FAIL steps2: valid=%b data=%h, want 1 c0300002", valid_b, data_b);
    end
  endtask

  task automatic test_zero_seed();
    load_a = 1; lval_a = 32'h0;
    @(negedge clk);
    load_a = 0;
    vectors++;
    if (data_a !== 32'h1 || zs_a !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_seed_load: data=%h zs=%b, want 00000001 1", data_a, zs_a);
    end
    @(negedge clk);
    vectors++;
    if (zs_a !== 1'b0 || data_a !== 32'h1) begin
      miscompares++;
      $display("FAIL zero_seed_pulse: zs=%b data=%h, want 0 00000001", zs_a, data_a);
    end
  endtask

  task automatic test_load_priority();
    load_a = 1; ready_a = 1; lval_a = 32'hDEAD_BEEF;
    @(negedge clk);
    load_a = 0; ready_a = 0;
    vectors++;
    if (data_a !== 32'hDEAD_BEEF || zs_a !== 1'b0 || valid_a !== 1'b1) begin
      miscompares++;
      $display("FAIL load_prio: data=%h zs=%b valid=%b, want deadbeef 0 1", data_a, zs_a, valid_a);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (data_a !== 32'hDEAD_BEEF) begin
        miscompares++;
        $display("FAIL stall%0d: data=%h, want deadbeef", i, data_a);
      end
    end
    ready_a = 1;
    @(negedge clk);
    ready_a = 0;
    vectors++;
    if (data_a !== 32'hEF76_DF74) begin
      miscompares++;
      $display("FAIL post_stall_step: data=%h, want ef76df74", data_a);
    end
  endtask

  task automatic test_back_to_back_load();
    logic [31:0] vals [3];
    vals = '{32'h1234_5678, 32'h0BAD_F00D, 32'h0000_0080};
    ready_a = 1;
    for (int i = 0; i < 3; i++) begin
      load_a = 1; lval_a = vals[i];
      @(negedge clk);
      vectors++;
      if (data_a !== vals[i]) begin
        miscompares++;
        $display("FAIL held_load%0d: data=%h, want %h", i, data_a, vals[i]);
      end
    end
    load_a = 0;
    @(negedge clk);
    ready_a = 0;
    vectors++;
    if (data_a !== 32'h0000_0040) begin
      miscompares++;
      $display("FAIL held_load_release: data=%h, want 00000040", data_a);
    end
  endtask

  task automatic test_period();
    logic [3:0] exp_seq [16];
    exp_seq = '{4'h1, 4'h9, 4'hD, 4'hF, 4'hE, 4'h7, 4'hA, 4'h5,
                4'hB, 4'hC, 4'h6, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1};
    load_c = 1; lval_c = 4'h1;
    @(negedge clk);
    load_c = 0;
    vectors++;
    if (data_c !== exp_seq[0] || valid_c !== 1'b1) begin
      miscompares++;
      $display("FAIL w4_load: data=%h valid=%b, want 1 1", data_c, valid_c);
    end
    ready_c = 1;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      vectors++;
      if (data_c !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL w4_step%0d: data=%h, want %h", i, data_c, exp_seq[i]);
      end
`ifdef LFSR_GEN_PERIOD_CHK_EN
      vectors++;
      if (wrap_c !== (i == 15)) begin
        miscompares++;
        $display("FAIL w4_wrap%0d: wrap=%b, want %b", i, wrap_c, (i == 15));
      end
`endif
    end
    ready_c = 0;
    vectors++;
`ifdef LFSR_GEN_PERIOD_CHK_EN
    if (period_c !== 4'd15) begin
      miscompares++;
      $display("FAIL w4_period: period=%0d, want 15", period_c);
    end
`else
    if (period_c !== 4'd0 || wrap_c !== 1'b0) begin
      miscompares++;
      $display("FAIL w4_period_off: period=%0d wrap=%b, want 0 0", period_c, wrap_c);
    end
`endif
    @(negedge clk);
    vectors++;
    if (wrap_c !== 1'b0) begin
      miscompares++;
      $display("FAIL w4_wrap_pulse: wrap=%b, want 0", wrap_c);
    end
  endtask

  task automatic test_async_reset();
    load_a = 1; lval_a = 32'h5555_AAAA;
    @(negedge clk);
    load_a = 0; ready_a = 1; ready_c = 1;
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (valid_a !== 1'b0 || data_a !== 32'h1) begin
      miscompares++;
      $display("FAIL async_reset_a: valid=%b data=%h, want 0 00000001", valid_a, data_a);
    end
    vectors++;
    if (valid_c !== 1'b0 || data_c !== 4'h1 || period_c !== 4'h0) begin
      miscompares++;
      $display("FAIL async_reset_c: valid=%b data=%h period=%h, want 0 1 0", valid_c, data_c, period_c);
    end
    ready_a = 0; ready_c = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_steps2();
    test_zero_seed();
    test_load_priority();
    test_back_to_back_load();
    test_period();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
